matrix_framebuffer: RTL and testbench

- Double-buffered 8x8 frame store that sits directly upstream of the LED matrix driver and supplies its 64-bit `matdata` frame.
- Upstream logic edits a back buffer row by row, clears it, or commits it. A commit copies the back buffer to the front buffer, aligned to a frame boundary so the scanned image never tears.
- The front buffer drives `matdata` directly.

---
 rtl/matrix_framebuffer.sv | 111 +++++++++++
 tb/tb_matrix_framebuffer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/matrix_framebuffer.sv
// Double-buffered 8x8 frame store feeding the LED matrix driver.
// Upstream edits/clears the back buffer; a commit copies it to the front buffer on a frame boundary.
module matrix_framebuffer #(
  parameter int unsigned SYNC_SWAP  = 1,
  parameter int unsigned CLEAR_ROWS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            wr_en,
  input  logic [2:0]      wr_row,
  input  logic [7:0]      wr_data,
  input  logic            clear_req,
  input  logic            swap_req,
  input  logic            frame_sync,
  output logic [7:0][7:0] matdata,
  output logic            busy,
  output logic            swap_pending,
  output logic            swap_done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    WAIT_SYNC = 2'd2
  } state_t;

  localparam logic [2:0] LAST_ROW = 3'(CLEAR_ROWS - 1);

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0][7:0] back_q, back_d;
  logic [7:0][7:0] front_q, front_d;
  logic            done_q;
  logic            swap_fire;
  logic [7:0]      row_wr;
  logic [7:0]      row_clr;

  // Next-state logic; nothing advances unless en is high.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    swap_fire = 1'b0;
    row_wr    = '0;
    row_clr   = '0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_d = CLEAR;
            cnt_d   = 3'd0;
          end else begin
            if (wr_en) begin
              row_wr[wr_row] = 1'b1;
            end
            if (swap_req) begin
              state_d = WAIT_SYNC;
            end
          end
        end
        CLEAR: begin
          row_clr[cnt_q] = 1'b1;
          cnt_d          = cnt_q + 3'd1;
          if (cnt_q == LAST_ROW) begin
            state_d = IDLE;
          end
        end
        WAIT_SYNC: begin
          if ((SYNC_SWAP == 0) || frame_sync) begin
            swap_fire = 1'b1;
            state_d   = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Per-row back-buffer update: clear sweep and upstream writes are mutually exclusive by state.
  for (genvar gi = 0; gi < 8; gi++) begin : g_back_row
    assign back_d[gi] = row_clr[gi] ? 8'h00 :
                        row_wr[gi]  ? wr_data : back_q[gi];
  end

  // Commit is a copy, so the back buffer keeps its image for further edits.
  assign front_d = swap_fire ? back_q : front_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      back_q  <= '0;
      front_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      back_q  <= back_d;
      front_q <= front_d;
      done_q  <= swap_fire;
    end
  end

  assign matdata      = front_q;
  assign busy         = (state_q != IDLE);
  assign swap_pending = (state_q == WAIT_SYNC);
  assign swap_done    = done_q;

endmodule

// File: tb/tb_matrix_framebuffer.sv
// Directed, table-driven check of matrix_framebuffer (synced and unsynced builds share the inputs).
module tb_matrix_framebuffer;

  logic            clk = 1'b0;
  logic            rst, en, wr_en, clear_req, swap_req, frame_sync;
  logic [2:0]      wr_row;
  logic [7:0]      wr_data;
  logic [7:0][7:0] mat_s, mat_n;
  logic            busy_s, pend_s, done_s, busy_n, pend_n, done_n;

  always #5 clk = ~clk;

  matrix_framebuffer #(.SYNC_SWAP(1), .CLEAR_ROWS(8)) u_sync (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .clear_req(clear_req), .swap_req(swap_req), .frame_sync(frame_sync),
    .matdata(mat_s), .busy(busy_s), .swap_pending(pend_s), .swap_done(done_s)
  );

  matrix_framebuffer #(.SYNC_SWAP(0), .CLEAR_ROWS(8)) u_nosync (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .clear_req(clear_req), .swap_req(swap_req), .frame_sync(frame_sync),
    .matdata(mat_n), .busy(busy_n), .swap_pending(pend_n), .swap_done(done_n)
  );

  typedef struct {
    logic        rst, en, wr, clr, swp, fs;
    logic [2:0]  row;
    logic [7:0]  data;
    logic [63:0] mat;
    logic        busy, pend, done;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  localparam logic [63:0] PAT = 64'h8142241818244281;
  localparam logic [63:0] ALL = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] R2  = 64'h0000000000550000;
  localparam logic [63:0] R4  = 64'h0000009900000000;

  function automatic vec_t mk(input logic r, input logic e, input logic w, input logic [2:0] row,
                              input logic [7:0] d, input logic c, input logic s, input logic f,
                              input logic [63:0] m, input logic b, input logic p, input logic dn);
    vec_t v;
    v.rst = r; v.en = e; v.wr = w; v.row = row; v.data = d; v.clr = c; v.swp = s; v.fs = f;
    v.mat = m; v.busy = b; v.pend = p; v.done = dn;
    return v;
  endfunction

  function automatic vec_t idl(input logic [63:0] m, input logic b, input logic p, input logic dn);
    return mk(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, m, b, p, dn);
  endfunction

  // Drive on the falling edge, check 1 time unit after the rising edge.
  task automatic apply(input vec_t v, input bit nosync);
    logic [63:0] m;
    logic        b, p, d;
    @(negedge clk);
    rst = v.rst; en = v.en; wr_en = v.wr; wr_row = v.row; wr_data = v.data;
    clear_req = v.clr; swap_req = v.swp; frame_sync = v.fs;
    @(posedge clk);
    #1;
    if (nosync) begin
      m = mat_n; b = busy_n; p = pend_n; d = done_n;
    end else begin
      m = mat_s; b = busy_s; p = pend_s; d = done_s;
    end
    if (m !== v.mat || b !== v.busy || p !== v.pend || d !== v.done) begin
      n_bad++;
      $display("FAIL vec %0d (%s): matdata=%h busy=%b pend=%b done=%b, want matdata=%h busy=%b pend=%b done=%b",
               n_vec, nosync ? "nosync" : "sync", m, b, p, d, v.mat, v.busy, v.pend, v.done);
    end
    n_vec++;
  endtask

  initial begin
    logic [7:0] pat [8];
    pat[0] = 8'h81; pat[1] = 8'h42; pat[2] = 8'h24; pat[3] = 8'h18;
    pat[4] = 8'h18; pat[5] = 8'h24; pat[6] = 8'h42; pat[7] = 8'h81;

    rst = 1'b1; en = 1'b1; wr_en = 1'b0; wr_row = 3'd0; wr_data = 8'h00;
    clear_req = 1'b0; swap_req = 1'b0; frame_sync = 1'b0;

    // Reset then idle
    vq.push_back(mk(1, 1, 0, 0, 8'h00, 0, 0, 0, 64'h0, 0, 0, 0));
    for (int i = 0; i < 20; i++) vq.push_back(idl(64'h0, 0, 0, 0));
    // Pattern load, swap held off without frame_sync
    for (int r = 0; r < 8; r++) vq.push_back(mk(0, 1, 1, 3'(r), pat[r], 0, 0, 0, 64'h0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 0, 1, 0, 64'h0, 1, 1, 0));
    for (int i = 0; i < 10; i++) vq.push_back(idl(64'h0, 1, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, PAT, 0, 0, 1));
    vq.push_back(idl(PAT, 0, 0, 0));
    // Commit all-FF, then clear: 8 busy cycles, requests ignored, front untouched
    for (int r = 0; r < 8; r++) vq.push_back(mk(0, 1, 1, 3'(r), 8'hFF, 0, 0, 0, PAT, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 0, 1, 0, PAT, 1, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, ALL, 0, 0, 1));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 1, 0, 0, ALL, 1, 0, 0));
    for (int i = 0; i < 6; i++) vq.push_back(mk(0, 1, 0, 0, 8'h00, 0, (i == 2), (i == 3), ALL, 1, 0, 0));
    vq.push_back(idl(ALL, 1, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 8'h11, 0, 0, 0, ALL, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 0, 1, 0, ALL, 1, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 64'h0, 0, 0, 1));
    // Same-cycle collisions
    vq.push_back(mk(0, 1, 1, 3, 8'hAA, 1, 0, 0, 64'h0, 1, 0, 0));
    for (int i = 0; i < 7; i++) vq.push_back(idl(64'h0, 1, 0, 0));
    vq.push_back(idl(64'h0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 2, 8'h55, 0, 1, 0, 64'h0, 1, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, R2, 0, 0, 1));
    // Requests while waiting are ignored; frame_sync in IDLE is not remembered
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 0, 1, 0, R2, 1, 1, 0));
    vq.push_back(mk(0, 1, 1, 5, 8'hF0, 0, 0, 0, R2, 1, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 1, 0, 0, R2, 1, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, R2, 0, 0, 1));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, R2, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 0, 1, 0, R2, 1, 1, 0));
    vq.push_back(idl(R2, 1, 1, 0));
    vq.push_back(idl(R2, 1, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, R2, 0, 0, 1));

    foreach (vq[i]) apply(vq[i], 1'b0);

    // Enable dropped at counter=3 for 5 cycles: clear stretches to 13 busy cycles
    apply(mk(0, 1, 0, 0, 8'h00, 1, 0, 0, R2, 1, 0, 0), 1'b0);
    for (int i = 0; i < 3; i++) apply(idl(R2, 1, 0, 0), 1'b0);
    for (int i = 0; i < 5; i++) apply(mk(0, 0, 0, 0, 8'h00, 0, 1, 1, R2, 1, 0, 0), 1'b0);
    for (int i = 0; i < 4; i++) apply(idl(R2, 1, 0, 0), 1'b0);
    apply(idl(R2, 0, 0, 0), 1'b0);

    // frame_sync with en low is lost; reset aborts the pending swap
    apply(mk(0, 1, 1, 1, 8'h3C, 0, 1, 0, R2, 1, 1, 0), 1'b0);
    apply(mk(0, 0, 0, 0, 8'h00, 0, 0, 1, R2, 1, 1, 0), 1'b0);
    apply(idl(R2, 1, 1, 0), 1'b0);
    apply(mk(1, 1, 0, 0, 8'h00, 0, 0, 1, 64'h0, 0, 0, 0), 1'b0);
    apply(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 64'h0, 0, 0, 0), 1'b0);
    apply(idl(64'h0, 0, 0, 0), 1'b0);

    // Unsynced build: commit lands two edges after the request with no frame_sync
    apply(mk(0, 1, 1, 4, 8'h99, 0, 1, 0, 64'h0, 1, 1, 0), 1'b1);
    apply(idl(R4, 0, 0, 1), 1'b1);
    apply(idl(R4, 0, 0, 0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
